// File: rtl/rstp_desc_pkg.sv
// rstp_desc_pkg: register map, constants and descriptor type for the RDDM descriptor engine
package rstp_desc_pkg;
  localparam logic [11:0] A_VER    = 12'h000;
  localparam logic [11:0] A_VER_HI = 12'h004;
  localparam logic [11:0] A_CTRL   = 12'h020;
  localparam logic [11:0] A_MEM    = 12'h024;
  localparam logic [11:0] A_DESC   = 12'h02C;
  localparam logic [11:0] A_ERR    = 12'h030;
  localparam logic [11:0] A_MASK   = 12'h048;
  localparam logic [11:0] A_SLOT   = 12'h100;
  localparam logic [11:0] A_LEN    = 12'h108;
  localparam logic [11:0] A_START  = 12'h10C;
  localparam logic [11:0] A_CONN   = 12'h110;
  localparam logic [11:0] A_CHAN   = 12'h114;
  localparam logic [11:0] A_TLEN   = 12'h208;
  localparam logic [11:0] A_TSTART = 12'h20C;
  localparam logic [11:0] A_TCONN  = 12'h210;
  localparam logic [11:0] A_TCHAN  = 12'h214;
  localparam logic [11:0] A_TPOP   = 12'h218;
  localparam logic [31:0] VER      = 32'h5244_444D;
  localparam logic [31:0] FAULT    = 32'hDEAD_C0DE;
  localparam int ERR_CHAN  = 0;
  localparam int ERR_OVF   = 1;
  localparam int ERR_EMPTY = 2;
  typedef struct packed {
    logic [30:0] len;
    logic        eop;
    logic [31:0] start;
    logic [31:0] conn;
    logic [3:0]  chan;
  } desc_t;
endpackage

// File: rtl/rstp_desc_fifo.sv
// rstp_desc_fifo: synchronous descriptor FIFO with occupancy count and soft flush
module rstp_desc_fifo
  import rstp_desc_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  desc_t                  din,
  output desc_t                  dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  desc_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign wr = push && cnt_q != (AW+1)'(DEPTH);
  assign rd = pop && cnt_q != '0;
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(wr);
      rp_q <= rp_q + AW'(rd);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/rstp_desc_engine.sv
// rstp_desc_engine: RDDM CSR slave with H2T submission and slot accounting, T2H readout,
// loopback, soft flush, sticky errors and level interrupts.
module rstp_desc_engine
  import rstp_desc_pkg::*;
#(
  parameter int DESC_DEPTH   = 32,
  parameter int MEM_DEPTH    = 4096,
  parameter int NUM_CHANNELS = 4,
  parameter int CW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          csr_wr,
  input  logic          csr_rd,
  input  logic [11:0]   csr_addr,
  input  logic [31:0]   csr_wdata,
  output logic [31:0]   csr_rdata,
  output logic          csr_rvalid,
  output logic          h2t_desc_valid,
  input  logic          h2t_desc_ready,
  output logic [30:0]   h2t_desc_len,
  output logic          h2t_desc_eop,
  output logic [31:0]   h2t_desc_start,
  output logic [31:0]   h2t_desc_conn,
  output logic [CW-1:0] h2t_desc_chan,
  input  logic          h2t_desc_done,
  input  logic          t2h_desc_valid,
  output logic          t2h_desc_ready,
  input  logic [30:0]   t2h_desc_len,
  input  logic          t2h_desc_eop,
  input  logic [31:0]   t2h_desc_start,
  input  logic [31:0]   t2h_desc_conn,
  input  logic [CW-1:0] t2h_desc_chan,
  output logic          irq_h2t,
  output logic          irq_t2h
);
  localparam int IW = $clog2(DESC_DEPTH) + 1;
  desc_t h2t_head, t2h_head, t2h_din;
  logic [IW-1:0] h2t_cnt, t2h_cnt, inflight_q, inflight_d, slot_avail;
  logic [30:0] len_q, len_d;
  logic [31:0] start_q, start_d, conn_q, conn_d, rdata_q, rdata_d;
  logic [2:0] err_q, err_d, err_new;
  logic [1:0] mask_q, mask_d;
  logic eop_q, eop_d, lpbk_q, lpbk_d, pend_q, pend_d, rdy_q, rvalid_q;
  logic h2t_empty, t2h_empty, t2h_full, flush, commit, bad_chan, commit_ok;
  logic move, free, pop_req, t2h_pop, t2h_push;
  assign h2t_empty = h2t_cnt == '0;
  assign t2h_empty = t2h_cnt == '0;
  assign t2h_full = t2h_cnt == IW'(DESC_DEPTH);
  assign slot_avail = IW'(DESC_DEPTH) - inflight_q;
  assign flush = csr_wr && csr_addr == A_CTRL && csr_wdata[0];
  assign commit = csr_wr && csr_addr == A_CHAN;
  assign bad_chan = csr_wdata >= 32'(NUM_CHANNELS);
  assign commit_ok = commit && !bad_chan && slot_avail != '0;
  // loopback hands the H2T head straight to T2H and frees its slot in the same cycle
  assign move = lpbk_q && !h2t_empty && !t2h_full;
  assign free = lpbk_q ? move : h2t_desc_done && inflight_q != '0;
  assign pop_req = csr_wr && csr_addr == A_TPOP;
  assign t2h_pop = pop_req && !t2h_empty;
  assign h2t_desc_valid = !lpbk_q && !h2t_empty;
  assign t2h_desc_ready = rdy_q && !t2h_full && !lpbk_q;
  assign t2h_push = move || (t2h_desc_valid && t2h_desc_ready);
  assign t2h_din = move ? h2t_head : desc_t'({t2h_desc_len, t2h_desc_eop, t2h_desc_start,
                                              t2h_desc_conn, 4'(t2h_desc_chan)});
  assign h2t_desc_len = h2t_head.len;
  assign h2t_desc_eop = h2t_head.eop;
  assign h2t_desc_start = h2t_head.start;
  assign h2t_desc_conn = h2t_head.conn;
  assign h2t_desc_chan = h2t_head.chan[CW-1:0];
  assign csr_rdata = rdata_q;
  assign csr_rvalid = rvalid_q;
  assign irq_h2t = pend_q && !mask_q[0];
  assign irq_t2h = !t2h_empty && !mask_q[1];
  rstp_desc_fifo #(.DEPTH(DESC_DEPTH)) u_h2t (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(commit_ok),
    .pop(move || (h2t_desc_valid && h2t_desc_ready)),
    .din(desc_t'({len_q, eop_q, start_q, conn_q, csr_wdata[3:0]})),
    .dout(h2t_head), .count(h2t_cnt)
  );
  rstp_desc_fifo #(.DEPTH(DESC_DEPTH)) u_t2h (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(t2h_push), .pop(t2h_pop),
    .din(t2h_din), .dout(t2h_head), .count(t2h_cnt)
  );
  always_comb begin
    err_new = '0;
    err_new[ERR_CHAN] = commit && bad_chan;
    err_new[ERR_OVF] = commit && !bad_chan && slot_avail == '0;
    err_new[ERR_EMPTY] = pop_req && t2h_empty;
    err_d = flush ? '0 : ((csr_rd && csr_addr == A_ERR) ? '0 : err_q) | err_new;
    inflight_d = flush ? '0 : inflight_q + IW'(commit_ok) - IW'(free);
    pend_d = !flush && (free || (pend_q && !(csr_rd && csr_addr == A_SLOT)));
    lpbk_d = (csr_wr && csr_addr == A_CTRL) ? csr_wdata[8] : lpbk_q;
    mask_d = (csr_wr && csr_addr == A_MASK) ? csr_wdata[1:0] : mask_q;
    {eop_d, len_d} = flush ? '0 : (csr_wr && csr_addr == A_LEN) ? csr_wdata : {eop_q, len_q};
    start_d = flush ? '0 : (csr_wr && csr_addr == A_START) ? csr_wdata : start_q;
    conn_d = flush ? '0 : (csr_wr && csr_addr == A_CONN) ? csr_wdata : conn_q;
  end
  always_comb begin
    rdata_d = FAULT;
    case (csr_addr)
      A_VER:    rdata_d = VER;
      A_VER_HI: rdata_d = '0;
      A_CTRL:   rdata_d = {23'd0, lpbk_q, 8'd0};
      A_MEM:    rdata_d = 32'(MEM_DEPTH);
      A_DESC:   rdata_d = 32'(DESC_DEPTH);
      A_ERR:    rdata_d = {29'd0, err_q};
      A_MASK:   rdata_d = {30'd0, mask_q};
      A_SLOT:   rdata_d = 32'(slot_avail);
      A_TLEN:   rdata_d = t2h_empty ? '0 : {t2h_head.eop, t2h_head.len};
      A_TSTART: rdata_d = t2h_empty ? '0 : t2h_head.start;
      A_TCONN:  rdata_d = t2h_empty ? '0 : t2h_head.conn;
      A_TCHAN:  rdata_d = t2h_empty ? '0 : {28'd0, t2h_head.chan};
      default:  rdata_d = FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inflight_q <= '0;
      err_q <= '0;
      pend_q <= 1'b0;
      lpbk_q <= 1'b0;
      mask_q <= '0;
      eop_q <= 1'b0;
      len_q <= '0;
      start_q <= '0;
      conn_q <= '0;
      rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q <= err_d;
      pend_q <= pend_d;
      lpbk_q <= lpbk_d;
      mask_q <= mask_d;
      eop_q <= eop_d;
      len_q <= len_d;
      start_q <= start_d;
      conn_q <= conn_d;
      rdy_q <= 1'b1;
      rvalid_q <= csr_rd;
      if (csr_rd) rdata_q <= rdata_d;
    end
endmodule

// File: tb/tb_rstp_desc_engine.sv
// tb_rstp_desc_engine: directed stimulus checked against a queue-based model every cycle,
// plus hand-computed literal expectations.
module tb_rstp_desc_engine;
  import rstp_desc_pkg::*;
  localparam int D = 32;
  logic clk = 0, rst_n = 0, csr_wr = 0, csr_rd = 0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0, csr_rdata;
  logic csr_rvalid, h2t_desc_valid, h2t_desc_eop, irq_h2t, irq_t2h, t2h_desc_ready;
  logic h2t_desc_ready = 0, h2t_desc_done = 0, t2h_desc_valid = 0, t2h_desc_eop = 0;
  logic [30:0] h2t_desc_len, t2h_desc_len = '0;
  logic [31:0] h2t_desc_start, h2t_desc_conn, t2h_desc_start = '0, t2h_desc_conn = '0;
  logic [1:0] h2t_desc_chan, t2h_desc_chan = '0;
  always #5 clk = ~clk;

  rstp_desc_engine dut (
    .clk(clk), .rst_n(rst_n), .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
    .h2t_desc_valid(h2t_desc_valid), .h2t_desc_ready(h2t_desc_ready),
    .h2t_desc_len(h2t_desc_len), .h2t_desc_eop(h2t_desc_eop), .h2t_desc_start(h2t_desc_start),
    .h2t_desc_conn(h2t_desc_conn), .h2t_desc_chan(h2t_desc_chan), .h2t_desc_done(h2t_desc_done),
    .t2h_desc_valid(t2h_desc_valid), .t2h_desc_ready(t2h_desc_ready),
    .t2h_desc_len(t2h_desc_len), .t2h_desc_eop(t2h_desc_eop), .t2h_desc_start(t2h_desc_start),
    .t2h_desc_conn(t2h_desc_conn), .t2h_desc_chan(t2h_desc_chan),
    .irq_h2t(irq_h2t), .irq_t2h(irq_t2h)
  );

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h at %0t", n, act, exp, $time);
    end
  endtask

  // behavioural model: descriptor queues plus the architectural registers
  desc_t hq[$], tq[$];
  int inflight;
  logic [2:0] m_err;
  logic [1:0] m_mask;
  logic m_lpbk, m_pend, m_rdy, m_rvalid, s_eop;
  logic [31:0] m_rdata, s_start, s_conn;
  logic [30:0] s_len;

  task automatic m_reset();
    hq.delete(); tq.delete();
    inflight = 0; m_err = 0; m_mask = 0; m_lpbk = 0; m_pend = 0; m_rdy = 0;
    m_rvalid = 0; m_rdata = 0; s_eop = 0; s_len = 0; s_start = 0; s_conn = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    bit e = tq.size() == 0;
    case (a)
      12'h000: return 32'h5244444D;
      12'h004: return 0;
      12'h020: return {23'd0, m_lpbk, 8'd0};
      12'h024: return 4096;
      12'h02C: return D;
      12'h030: return {29'd0, m_err};
      12'h048: return {30'd0, m_mask};
      12'h100: return 32'(D - inflight);
      12'h208: return e ? 0 : {tq[0].eop, tq[0].len};
      12'h20C: return e ? 0 : tq[0].start;
      12'h210: return e ? 0 : tq[0].conn;
      12'h214: return e ? 0 : {28'd0, tq[0].chan};
      default: return 32'hDEADC0DE;
    endcase
  endfunction

  task automatic m_step();
    int h_n = hq.size(), t_n = tq.size(), pre_i = inflight;
    bit lp = m_lpbk, t_rdy = m_rdy && t_n < D && !m_lpbk, fset = 0, fl = 0;
    m_rvalid = csr_rd;
    if (csr_rd) m_rdata = m_read(csr_addr);
    if (csr_rd && csr_addr == 12'h030) m_err = 0;
    if (csr_rd && csr_addr == 12'h100) m_pend = 0;
    if (lp) begin
      if (h_n > 0 && t_n < D) begin tq.push_back(hq.pop_front()); inflight--; fset = 1; end
    end else begin
      if (h_n > 0 && h2t_desc_ready) void'(hq.pop_front());
      if (h2t_desc_done && pre_i > 0) begin inflight--; fset = 1; end
      if (t2h_desc_valid && t_rdy)
        tq.push_back('{len: t2h_desc_len, eop: t2h_desc_eop, start: t2h_desc_start,
                       conn: t2h_desc_conn, chan: 4'(t2h_desc_chan)});
    end
    if (csr_wr)
      case (csr_addr)
        12'h020: begin m_lpbk = csr_wdata[8]; fl = csr_wdata[0]; end
        12'h048: m_mask = csr_wdata[1:0];
        12'h108: {s_eop, s_len} = csr_wdata;
        12'h10C: s_start = csr_wdata;
        12'h110: s_conn = csr_wdata;
        12'h114:
          if (csr_wdata >= 4) m_err[0] = 1;
          else if (D - pre_i == 0) m_err[1] = 1;
          else begin
            hq.push_back('{len: s_len, eop: s_eop, start: s_start, conn: s_conn, chan: csr_wdata[3:0]});
            inflight++;
          end
        12'h218: if (t_n == 0) m_err[2] = 1; else void'(tq.pop_front());
        default: ;
      endcase
    if (fset) m_pend = 1;
    if (fl) begin
      hq.delete(); tq.delete();
      inflight = 0; m_err = 0; m_pend = 0; s_eop = 0; s_len = 0; s_start = 0; s_conn = 0;
    end
    m_rdy = 1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset(); else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("h2t_valid", 32'(h2t_desc_valid), 32'(!m_lpbk && hq.size() > 0));
      if (!m_lpbk && hq.size() > 0) begin
        chk("h2t_len", 32'(h2t_desc_len), 32'(hq[0].len));
        chk("h2t_eop", 32'(h2t_desc_eop), 32'(hq[0].eop));
        chk("h2t_start", h2t_desc_start, hq[0].start);
        chk("h2t_conn", h2t_desc_conn, hq[0].conn);
        chk("h2t_chan", 32'(h2t_desc_chan), 32'(hq[0].chan));
      end
      chk("t2h_ready", 32'(t2h_desc_ready), 32'(m_rdy && tq.size() < D && !m_lpbk));
      chk("irq_h2t", 32'(irq_h2t), 32'(m_pend && !m_mask[0]));
      chk("irq_t2h", 32'(irq_t2h), 32'(tq.size() > 0 && !m_mask[1]));
      chk("rvalid", 32'(csr_rvalid), 32'(m_rvalid));
      chk("rdata", csr_rdata, m_rdata);
    end
  end

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_wr = 1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_wr = 0;
  endtask
  task automatic rdchk(input string n, input logic [11:0] a, input logic [31:0] e);
    csr_rd = 1; csr_addr = a;
    @(negedge clk);
    csr_rd = 0;
    chk(n, csr_rdata, e);
  endtask
  task automatic commit(input logic [31:0] le, input logic [31:0] st, input logic [31:0] cn,
                        input logic [31:0] ch);
    wr(12'h108, le); wr(12'h10C, st); wr(12'h110, cn); wr(12'h114, ch);
  endtask
  task automatic t2h_push(input logic [30:0] l, input logic e, input logic [31:0] st,
                          input logic [31:0] cn, input logic [1:0] ch);
    t2h_desc_len = l; t2h_desc_eop = e; t2h_desc_start = st; t2h_desc_conn = cn;
    t2h_desc_chan = ch; t2h_desc_valid = 1;
    @(negedge clk);
    t2h_desc_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 32'(csr_rvalid), 0);
    chk("rst_rdata", csr_rdata, 0);
    chk("rst_h2t_valid", 32'(h2t_desc_valid), 0);
    chk("rst_t2h_ready", 32'(t2h_desc_ready), 0);
    chk("rst_irq", {30'd0, irq_h2t, irq_t2h}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("t2h_ready_after_rst", 32'(t2h_desc_ready), 1);
    rdchk("ver", 12'h000, 32'h5244444D);
    rdchk("ver_hi", 12'h004, 0);
    rdchk("mem_depth", 12'h024, 32'h1000);
    rdchk("desc_depth", 12'h02C, 32'h20);
    rdchk("slot_rst", 12'h100, 32'h20);
    rdchk("unmapped", 12'h300, 32'hDEADC0DE);
    rdchk("staging_unreadable", 12'h108, 32'hDEADC0DE);
    // single H2T descriptor, handshake, done
    commit(32'h8000_0040, 32'h100, 7, 2);
    chk("c1_valid", 32'(h2t_desc_valid), 1);
    chk("c1_len", 32'(h2t_desc_len), 32'h40);
    chk("c1_eop", 32'(h2t_desc_eop), 1);
    chk("c1_chan", 32'(h2t_desc_chan), 2);
    chk("c1_start", h2t_desc_start, 32'h100);
    chk("c1_conn", h2t_desc_conn, 7);
    rdchk("slot_1f", 12'h100, 32'h1F);
    h2t_desc_ready = 1; @(negedge clk); h2t_desc_ready = 0;
    chk("c1_popped", 32'(h2t_desc_valid), 0);
    h2t_desc_done = 1; @(negedge clk); h2t_desc_done = 0;
    chk("irq_h2t_set", 32'(irq_h2t), 1);
    rdchk("slot_back", 12'h100, 32'h20);
    chk("irq_h2t_clr", 32'(irq_h2t), 0);
    // bad channel
    wr(12'h114, 4);
    chk("bad_chan_drop", 32'(h2t_desc_valid), 0);
    rdchk("err_chan", 12'h030, 1);
    rdchk("err_clr", 12'h030, 0);
    // overflow with staging reused
    for (int i = 0; i < 33; i++) wr(12'h114, 1);
    rdchk("slot_zero", 12'h100, 0);
    rdchk("err_ovf", 12'h030, 2);
    wr(12'h114, 5);
    rdchk("err_prio", 12'h030, 1);
    chk("persist_len", 32'(h2t_desc_len), 32'h40);
    wr(12'h020, 1);
    rdchk("flush_slot", 12'h100, 32'h20);
    chk("flush_h2t", 32'(h2t_desc_valid), 0);
    rdchk("ctrl_bit0_zero", 12'h020, 0);
    // T2H readout and pop
    t2h_push(31'h11, 0, 32'hA000, 32'h55, 3);
    t2h_push(31'h7FFF_FFFF, 1, 32'hB000, 32'h66, 1);
    chk("irq_t2h_set", 32'(irq_t2h), 1);
    rdchk("t_len_a", 12'h208, 32'h11);
    rdchk("t_start_a", 12'h20C, 32'hA000);
    rdchk("t_conn_a", 12'h210, 32'h55);
    rdchk("t_chan_a", 12'h214, 3);
    wr(12'h218, 0);
    rdchk("t_len_b", 12'h208, 32'hFFFF_FFFF);
    rdchk("t_chan_b", 12'h214, 1);
    wr(12'h218, 0);
    chk("irq_t2h_clr", 32'(irq_t2h), 0);
    rdchk("t_empty", 12'h208, 0);
    wr(12'h218, 0);
    rdchk("err_empty_pop", 12'h030, 4);
    // masks and T2H full
    wr(12'h048, 3);
    t2h_push(31'h99, 0, 1, 2, 0);
    chk("irq_t2h_masked", 32'(irq_t2h), 0);
    rdchk("mask_rd", 12'h048, 3);
    wr(12'h048, 0);
    chk("irq_t2h_unmasked", 32'(irq_t2h), 1);
    t2h_desc_valid = 1;
    for (int i = 0; i < 40; i++) begin
      t2h_desc_len = 31'(i + 1); t2h_desc_start = 32'(i); @(negedge clk);
    end
    t2h_desc_valid = 0;
    chk("t2h_full_ready", 32'(t2h_desc_ready), 0);
    rdchk("t2h_full_head", 12'h208, 32'h99);
    wr(12'h020, 1);
    chk("t2h_flush_irq", 32'(irq_t2h), 0);
    chk("t2h_flush_ready", 32'(t2h_desc_ready), 1);
    // loopback
    wr(12'h020, 32'h100);
    chk("lpbk_ready", 32'(t2h_desc_ready), 0);
    commit(32'h10, 32'h1000, 32'hC0, 0);
    commit(32'h20, 32'h2000, 32'hC1, 1);
    commit(32'h30, 32'h3000, 32'hC2, 2);
    repeat (2) @(negedge clk);
    chk("lpbk_no_h2t", 32'(h2t_desc_valid), 0);
    chk("lpbk_irq_h2t", 32'(irq_h2t), 1);
    rdchk("lpbk_slot", 12'h100, 32'h20);
    rdchk("lp_len0", 12'h208, 32'h10);
    rdchk("lp_chan0", 12'h214, 0);
    wr(12'h218, 0);
    rdchk("lp_len1", 12'h208, 32'h20);
    rdchk("lp_chan1", 12'h214, 1);
    wr(12'h218, 0);
    rdchk("lp_len2", 12'h208, 32'h30);
    rdchk("lp_start2", 12'h20C, 32'h3000);
    wr(12'h020, 32'h101);
    rdchk("lp_flush_empty", 12'h208, 0);
    chk("lp_flush_irq", 32'(irq_t2h), 0);
    rdchk("lp_kept", 12'h020, 32'h100);
    wr(12'h020, 0);
    // mid-operation reset
    commit(5, 1, 2, 3);
    chk("pre_rst_valid", 32'(h2t_desc_valid), 1);
    #2 rst_n = 0;
    #1 chk("mid_rst_valid", 32'(h2t_desc_valid), 0);
    chk("mid_rst_ready", 32'(t2h_desc_ready), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    rdchk("post_rst_slot", 12'h100, 32'h20);
    rdchk("post_rst_ctrl", 12'h020, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rstp_desc_engine.md
# rstp_desc_engine

Parametrised remote-STP debug-interface descriptor engine: a 32-bit CSR slave exposing the RDDM register map, H2T descriptor submission with slot accounting, T2H descriptor readout with done-pop, and interrupts. Generalises the fixed 32-descriptor/4 KB debug IP to configurable descriptor depth, memory depth and channel count. Adds channel-range checking, sticky error status, soft flush and internal loopback. Sits between the PCIe-side CSR bridge at `PORT_STP_DFH_ADDR + 0x1000` and the H2T/T2H packet movers.

## Interface
- `DESC_DEPTH`, 32: H2T and T2H descriptor FIFO depth; power of 2, 4..256.
- `MEM_DEPTH`, 4096: reported in `EXT_MEM_DEPTH` (bytes); no internal use.
- `NUM_CHANNELS`, 4: valid channel IDs are 0..NUM_CHANNELS-1; 1..16.
- `CW`, $clog2(NUM_CHANNELS) min 1: channel field width.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `csr_wr`, `csr_rd` in 1: single-cycle strobes; never both high.
- `csr_addr` in 12: byte offset, 4-byte aligned.
- `csr_wdata` in 32: write data.
- `csr_rdata` out 32, `csr_rvalid` out 1: read response.
- `h2t_desc_valid` out 1, `h2t_desc_ready` in 1: H2T descriptor handshake.
- `h2t_desc_len` out 31, `h2t_desc_eop` out 1, `h2t_desc_start` out 32, `h2t_desc_conn` out 32, `h2t_desc_chan` out CW: H2T descriptor fields.
- `h2t_desc_done` in 1: pulse; mover finished one descriptor and frees one slot.
- `t2h_desc_valid` in 1, `t2h_desc_ready` out 1: T2H descriptor handshake; fields use the H2T widths, prefixed `t2h_desc_`.
- `irq_h2t`, `irq_t2h` out 1: level interrupts, registered.

## Operation
- Reads:
  - 0x000 returns 0x5244_444D; 0x004 returns 0.
  - 0x020 CTRL: bit8 `lpbk` (RW); bit0 reads 0.
  - 0x024 returns MEM_DEPTH; 0x02C returns DESC_DEPTH.
  - 0x030 ERR (new): sticky bits; read clears. [0] bad channel, [1] H2T overflow, [2] DESC_DONE while T2H empty.
  - 0x048 INTR_MASK, [1:0] RW; 1 = masked.
  - Any unlisted offset returns 0xDEAD_C0DE; writes to unlisted offsets are ignored.
- H2T staging:
  - Writes to 0x108 (LEN[30:0], EOP[31]), 0x10C (START) and 0x110 (CONN) load staging registers.
  - A write to 0x114 (CHANNEL) commits staging plus chan into the H2T FIFO.
  - Commit is dropped and ERR[0] set if chan ≥ NUM_CHANNELS. ERR[0] takes priority if both errors apply.
  - Commit is dropped and ERR[1] set if `slot_avail`=0.
  - Staging registers persist after commit.
- `inflight`: +1 on accepted commit, −1 on `h2t_desc_done`; both in the same cycle leaves it unchanged. 0x100 SLOT_AVAIL returns DESC_DEPTH−inflight.
- H2T FIFO head drives `h2t_desc_*`; pop on valid&ready.
- T2H:
  - Push on `t2h_desc_valid & t2h_desc_ready`; `t2h_desc_ready` = FIFO not full and `lpbk`=0.
  - 0x208/0x20C/0x210/0x214 return head LEN|EOP<<31, START, CONN, chan; all read 0 when the FIFO is empty.
  - A write to 0x218 pops the head; when the FIFO is empty it sets ERR[2] instead.
- Loopback (`lpbk`=1):
  - `h2t_desc_valid` is forced 0.
  - The H2T head moves into the T2H FIFO when T2H is not full, and `inflight` decrements that same cycle.
  - External `h2t_desc_done` is ignored.
- Soft flush: a write of 1 to CTRL bit0 empties both FIFOs and clears `inflight`, staging, ERR and `h2t_pend`. It does not change `lpbk` or the mask. It takes effect on the cycle after the write.
- Interrupts:
  - `h2t_pend` sets on each slot-freeing event and clears on a read of 0x100. Set wins over a same-cycle clear.
  - `irq_h2t` = `h2t_pend` & ~mask[0].
  - `irq_t2h` = T2H non-empty & ~mask[1].

## Timing
- `csr_rvalid` and `csr_rdata` are registered, one cycle after `csr_rd`. `csr_rdata` holds its value until the next read.
- A CSR write is visible to a read issued on the next cycle.
- Commit to `h2t_desc_valid`: 1 cycle.
- T2H push to head readable via CSR: 1 cycle.
- Full FIFO: `t2h_desc_ready`=0. Push and pop on the same cycle while full is not allowed, since ready is already low.
- Reset values:
  - `csr_rdata`=0, `csr_rvalid`=0.
  - `h2t_desc_valid`=0, `t2h_desc_ready`=0 during reset, then 1.
  - `irq_*`=0; all registers and FIFOs cleared.
- Mid-operation `rst_n` drops all queued descriptors. No partial handshake survives reset.

## Structure
- Package `rstp_desc_pkg` holds:
  - register offset localparams and the VER/FAULT constants;
  - the `desc_t` struct {len[30:0], eop, start[31:0], conn[31:0], chan[3:0]};
  - ERR bit indices.
- Sub-module `rstp_desc_fifo`: synchronous FIFO, parametrised depth and `desc_t` width, with a count output. It is instantiated twice.

## Test plan
- Reset, then read 0x000/0x024/0x02C/0x100/0x300 → 0x5244444D / 0x1000 / 0x20 / 0x20 / 0xDEADC0DE.
- Program LEN=0x8000_0040, START=0x100, CONN=7, CHANNEL=2 → next cycle `h2t_desc_valid` with len 0x40, eop 1, chan 2; SLOT_AVAIL=0x1F. Pulse done → 0x20 and `irq_h2t`=1; read 0x100 → irq clears.
- Commit with CHANNEL=4 (NUM_CHANNELS=4) → no descriptor; ERR reads 0x1, then 0x0.
- Hold `h2t_desc_ready`=0 and commit 33 times → 32 accepted, SLOT_AVAIL=0, ERR[1]=1.
- Push 2 T2H descriptors → `irq_t2h`=1 and the head fields are readable. Write 0x218 twice → `irq_t2h`=0. A third write sets ERR[2].
- With `lpbk`=1, commit 3 descriptors → 3 appear in T2H in order and SLOT_AVAIL=0x20. Soft flush → T2H empty and `lpbk` still 1.
